// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a pipeline stage boundary, with hazard-unit stall/bubble.
// Optional stall/bubble performance counters are compiled in by PIPE_SKID_REG_PERF_EN.
module pipe_skid_reg #(
  parameter int                 DATA_W      = 128,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] head_q, skid_q;
  logic              accept, pop;

  // Handshakes depend only on registered state and control inputs, never on in_data_i.
  assign in_ready_o  = (state_q != FULL)  & ~stall_i & ~rst_i;
  assign out_valid_o = (state_q != EMPTY) & ~stall_i & ~rst_i;
  assign out_data_o  = head_q;
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i & ~stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i) begin
      state_q <= EMPTY;
      head_q  <= BUBBLE_DATA;
      skid_q  <= '0;
    end else if (!stall_i) begin
      case (state_q)
        EMPTY: if (accept) begin
          head_q  <= in_data_i;
          state_q <= ONE;
        end
        ONE: begin
          if (pop && accept) begin
            head_q <= in_data_i;
          end else if (pop) begin
            state_q <= EMPTY;
          end else if (accept) begin
            skid_q  <= in_data_i;
            state_q <= FULL;
          end
        end
        FULL: if (pop) begin
          head_q  <= skid_q;
          state_q <= ONE;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_REG_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // A cycle with both stall and bubble counts only as a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_i && !bubble_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bubble_i && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule
